// File: rtl/uart_word_sender_if.sv
// uart_word_sender_if
// Bundles the word-feeder signals between the debug logic / UART transmitter
// side (master) and the word sender itself (slave).
//   wr_en, word_in   : word push from the debug logic
//   tx_done_tick     : end-of-frame pulse from the UART transmitter
//   tx_start         : one-cycle start pulse to the transmitter
//   data_out         : byte presented to the transmitter
//   full, empty      : word FIFO status
//   busy             : sender has work in flight or queued
//   overflow         : one-cycle pulse, a pushed word was dropped
interface uart_word_sender_if #(
  parameter int NBITS  = 8,
  parameter int NBYTES = 4
);
  logic                      wr_en;
  logic [NBITS*NBYTES-1:0]   word_in;
  logic                      tx_done_tick;
  logic                      tx_start;
  logic [NBITS-1:0]          data_out;
  logic                      full;
  logic                      empty;
  logic                      busy;
  logic                      overflow;

  modport master (
    output wr_en, word_in, tx_done_tick,
    input  tx_start, data_out, full, empty, busy, overflow
  );

  modport slave (
    input  wr_en, word_in, tx_done_tick,
    output tx_start, data_out, full, empty, busy, overflow
  );
endinterface

// File: rtl/uart_word_sender.sv
// uart_word_sender
// Queues NBYTES*NBITS-bit words in a small FIFO and feeds them to a UART
// transmitter one byte at a time, least-significant byte first. Each byte is
// offered with a one-cycle tx_start pulse; the next byte waits for the
// transmitter's tx_done_tick.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous, active-high
//   bus    : uart_word_sender_if.slave (word push, transmitter handshake,
//            FIFO status, busy and overflow)
//
// state | meaning
// IDLE  | no byte in flight; pops the FIFO head when a word is waiting
// SEND  | tx_start is high this cycle, data_out holds the current byte
// WAIT  | byte handed over, waiting for tx_done_tick from the transmitter
module uart_word_sender #(
  parameter int NBITS      = 8,
  parameter int NBYTES     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_word_sender_if.slave  bus
);
  localparam int W   = NBITS * NBYTES;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SEND = 3'b010,
    WAIT = 3'b100
  } state_t;

  state_t           state;
  logic [W-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [W-1:0]     shreg;
  logic [W-1:0]     shreg_next;
  logic [W-1:0]     head;
  logic [BCW-1:0]   byte_cnt;
  logic             tx_start_q;
  logic [NBITS-1:0] data_out_q;
  logic             overflow_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  // A word offered while full is dropped even if a pop frees a slot in the
  // same cycle, so acceptance depends only on the registered count.
  assign push       = bus.wr_en && !full;
  assign pop        = (state == IDLE) && !empty;
  assign head       = mem[rd_ptr];
  assign shreg_next = shreg >> NBITS;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.word_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= bus.wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // tx_start and data_out are registered on the transition into SEND, so
  // they line up with the SEND cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      byte_cnt   <= '0;
      tx_start_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg      <= head;
            byte_cnt   <= '0;
            data_out_q <= head[NBITS-1:0];
            tx_start_q <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done_tick) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= IDLE;
            end else begin
              shreg      <= shreg_next;
              byte_cnt   <= byte_cnt + BCW'(1);
              data_out_q <= shreg_next[NBITS-1:0];
              tx_start_q <= 1'b1;
              state      <= SEND;
            end
          end
        end
        default: begin
          state    <= IDLE;
          byte_cnt <= '0;
          shreg    <= '0;
        end
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.data_out = data_out_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state != IDLE) || !empty;
endmodule

// File: tb/tb_uart_word_sender.sv
module tb_uart_word_sender;
  localparam int NBITS  = 8;
  localparam int NBYTES = 4;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_word_sender_if #(.NBITS(NBITS), .NBYTES(NBYTES)) bus();

  uart_word_sender #(.NBITS(NBITS), .NBYTES(NBYTES), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic man_tick  = 1'b0;
  logic resp_tick = 1'b0;
  assign bus.tx_done_tick = man_tick | resp_tick;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  bit         outstanding = 0;
  logic [7:0] held = '0;
  bit         auto_resp = 0;
  int         fixed_dly = 0;
  int         resp_cnt = 0;
  int         tx_cnt = 0;
  int         ovf_cnt = 0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: bytes of a word, least-significant first.
  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
  endtask

  task automatic push(input logic [31:0] w);
    bus.wr_en   = 1'b1;
    bus.word_in = w;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic tick_bytes(input int n, input int gap, input logic busy_after);
    for (int b = 0; b < n; b++) begin
      repeat (gap) step();
      man_tick = 1'b1;
      step();
      man_tick = 1'b0;
      if (b < n - 1) chk("b2b_tx_start", bus.tx_start, 1);
      else begin
        chk("last_no_tx_start", bus.tx_start, 0);
        chk("busy_after_last", bus.busy, busy_after);
      end
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overflow", bus.overflow, 0);
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && (bus.busy || exp_q.size() != 0); i++) step();
    chk("drain_busy", bus.busy, 0);
    chk("drain_bytes_left", exp_q.size(), 0);
  endtask

  // Transmitter-side monitor and auto responder, evaluated mid-cycle.
  initial forever begin
    @(negedge clk);
    resp_tick = 1'b0;
    if (reset) begin
      outstanding = 0;
      resp_cnt    = 0;
    end else begin
      if (bus.overflow) ovf_cnt++;
      if (bus.tx_start) begin
        tx_cnt++;
        chk("tx_start_before_done", outstanding, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_tx_start: data_out=%02h, required no tx_start (t=%0t)", bus.data_out, $time);
        end else chk("byte", bus.data_out, exp_q.pop_front());
        outstanding = 1;
        held        = bus.data_out;
        if (auto_resp) resp_cnt = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 8));
      end else if (outstanding) begin
        chk("data_out_stable", bus.data_out, held);
        if (auto_resp && resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) resp_tick = 1'b1;
        end
        if (man_tick || resp_tick) outstanding = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, tx_base, occ, ovf_base, cyc;
    logic [31:0] w;

    vecs[0] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 20};
    vecs[1] = '{32'h0A0B0C0D, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 3};
    vecs[2] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12, 1};
    vecs[3] = '{32'h000000A5, 8'hA5, 8'h00, 8'h00, 8'h00, 2};
    vecs[4] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80, 5};
    vecs[5] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1};

    bus.wr_en   = 1'b0;
    bus.word_in = '0;
    step();
    step();
    chk_reset_vals();
    reset = 1'b0;
    step();

    // Table vectors: latency, byte order, byte-to-byte and busy timing.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      exp_q.push_back(vecs[v].b2);
      exp_q.push_back(vecs[v].b3);
      push(vecs[v].word);
      chk("lat_c1_tx_start", bus.tx_start, 0);
      chk("lat_c1_empty", bus.empty, 0);
      step();
      chk("lat_c2_tx_start", bus.tx_start, 1);
      tick_bytes(NBYTES, vecs[v].gap, 1'b0);
      step();
    end

    // Spurious done ticks in IDLE and in SEND.
    man_tick = 1'b1;
    step();
    man_tick = 1'b0;
    chk("spur_idle_tx_start", bus.tx_start, 0);
    chk("spur_idle_busy", bus.busy, 0);
    expect_word(32'hCAFEF00D);
    push(32'hCAFEF00D);
    step();
    chk("spur_send_tx_start", bus.tx_start, 1);
    man_tick = 1'b1;
    step();
    man_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("spur_send_no_start", bus.tx_start, 0);
      step();
    end
    tick_bytes(NBYTES, 2, 1'b0);
    step();

    // Fill / overflow with the FSM parked in WAIT.
    auto_resp = 1;
    fixed_dly = 40;
    ovf_base  = ovf_cnt;
    expect_word(32'h01020304);
    push(32'h01020304);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      w = 32'h11111111 * (i + 1);
      if (i < DEPTH) expect_word(w);
      bus.wr_en   = 1'b1;
      bus.word_in = w;
      step();
      if (i == 2) chk("fill_not_full", bus.full, 0);
      if (i == 3) begin
        chk("fill_full", bus.full, 1);
        chk("fill_no_ovf", bus.overflow, 0);
      end
      if (i == 4) chk("ovf_pulse", bus.overflow, 1);
    end
    bus.wr_en = 1'b0;
    step();
    chk("ovf_one_cycle", bus.overflow, 0);
    chk("ovf_still_full", bus.full, 1);
    fixed_dly = 0;
    wait_idle(2000);
    chk("ovf_count", ovf_cnt - ovf_base, 1);
    auto_resp = 0;

    // Reset in the middle of a word.
    expect_word(32'hA1A2A3A4);
    expect_word(32'hB1B2B3B4);
    push(32'hA1A2A3A4);
    push(32'hB1B2B3B4);
    chk("rw_byte0_start", bus.tx_start, 1);
    step();
    man_tick = 1'b1;
    step();
    man_tick = 1'b0;
    chk("rw_byte1_start", bus.tx_start, 1);
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
    chk_reset_vals();
    reset = 1'b0;
    step();
    expect_word(32'h0A0B0C0D);
    push(32'h0A0B0C0D);
    step();
    chk("rw_after_start", bus.tx_start, 1);
    tick_bytes(NBYTES, 2, 1'b0);
    step();

    // Push in the same cycle as the pop with one word queued.
    auto_resp = 1;
    fixed_dly = 40;
    expect_word(32'hC0C0C001);
    expect_word(32'hC0C0C002);
    expect_word(32'hC0C0C003);
    expect_word(32'hC0C0C004);
    expect_word(32'hC0C0C005);
    push(32'hC0C0C001);
    push(32'hC0C0C002);
    chk("pp_tx_start", bus.tx_start, 1);
    chk("pp_not_empty", bus.empty, 0);
    push(32'hC0C0C003);
    chk("pp_full_after_c", bus.full, 0);
    push(32'hC0C0C004);
    chk("pp_full_after_d", bus.full, 0);
    push(32'hC0C0C005);
    chk("pp_full_after_e", bus.full, 1);
    fixed_dly = 0;
    wait_idle(3000);

    // Randomized traffic against the byte-stream reference.
    ovf_base = ovf_cnt;
    tx_base  = tx_cnt;
    pushed   = 0;
    cyc      = 0;
    while (pushed < 60 && cyc < 4000) begin
      occ = pushed - (tx_cnt - tx_base + NBYTES - 1) / NBYTES;
      if (occ < DEPTH && $urandom_range(0, 2) == 0) begin
        w = $urandom;
        expect_word(w);
        bus.wr_en   = 1'b1;
        bus.word_in = w;
        pushed++;
      end else bus.wr_en = 1'b0;
      step();
      cyc++;
    end
    bus.wr_en = 1'b0;
    chk("rand_all_pushed", pushed, 60);
    wait_idle(5000);
    chk("rand_no_overflow", ovf_cnt - ovf_base, 0);
    chk("rand_byte_count", tx_cnt - tx_base, 60 * NBYTES);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
